// File: rtl/alu_issue_stage.sv
// ----------------------------------------------------------------------------
// common_pkg: shared RISC-V datapath width and ALU control encoding.
// alu_issue_stage: execute-stage wrapper that decodes ALUOp/funct fields,
// drives the combinational ALU from an issue register and captures its
// result into a result register handed to write-back over valid/ready.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               drop all in-flight ops (data regs and counter kept)
//   in_valid/in_ready   upstream op handshake (in_ready is combinational)
//   in_alu_op, in_funct3, in_funct7_b5, in_is_rtype  decode fields
//   in_a, in_b          signed operands
//   alu_a, alu_b, alu_ctrl   issue-register outputs to the ALU
//   alu_result, alu_zero     same-cycle ALU return
//   out_valid/out_ready      result handshake toward write-back
//   out_result, out_zero, out_illegal   registered result
//   retired_cnt         saturating count of result handshakes
// ----------------------------------------------------------------------------
package common_pkg;
  localparam int unsigned RISC_V_DATA_WIDTH = 32;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110
  } ALU_ctrl_t;
endpackage

module alu_issue_stage
  import common_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RISC_V_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_alu_op,
  input  logic [2:0]            in_funct3,
  input  logic                  in_funct7_b5,
  input  logic                  in_is_rtype,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output ALU_ctrl_t             alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_zero,
  output logic                  out_illegal,
  output logic [CNT_WIDTH-1:0]  retired_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic      s1_valid;
  logic      s1_illegal;
  logic      s1_adv;
  logic      accept;
  logic      advance;
  logic      retire;
  ALU_ctrl_t dec_ctrl;
  logic      dec_illegal;

  // Decode ALUOp/funct into an ALU operation; undecodable encodings run as ADD
  // and are flagged so the result stage can force a zero result.
  always_comb begin
    dec_ctrl    = ALU_ADD;
    dec_illegal = 1'b0;
    case (in_alu_op)
      2'b00: dec_ctrl = ALU_ADD;
      2'b01: dec_ctrl = ALU_SUB;
      2'b10: begin
        if (in_funct3 == 3'b000) begin
          dec_ctrl = (in_is_rtype && in_funct7_b5) ? ALU_SUB : ALU_ADD;
        end else if (in_is_rtype && in_funct7_b5) begin
          dec_illegal = 1'b1;
        end else if (in_funct3 == 3'b110) begin
          dec_ctrl = ALU_OR;
        end else if (in_funct3 == 3'b111) begin
          dec_ctrl = ALU_AND;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Pipeline handshake; flush blocks acceptance, advance and retirement.
  always_comb begin
    s1_adv   = !out_valid || out_ready;
    in_ready = !flush && (!s1_valid || s1_adv);
    accept   = in_valid && in_ready;
    advance  = s1_valid && s1_adv && !flush;
    retire   = out_valid && out_ready && !flush;
  end

  // Issue register, result register and retired-op counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_illegal  <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_ctrl    <= ALU_ADD;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_illegal <= 1'b0;
      retired_cnt <= '0;
    end else begin
      if (accept) begin
        alu_a      <= in_a;
        alu_b      <= in_b;
        alu_ctrl   <= dec_ctrl;
        s1_illegal <= dec_illegal;
      end

      if (flush) begin
        s1_valid <= 1'b0;
      end else if (accept) begin
        s1_valid <= 1'b1;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end

      if (advance) begin
        out_result  <= s1_illegal ? '0 : alu_result;
        out_zero    <= s1_illegal ? 1'b1 : alu_zero;
        out_illegal <= s1_illegal;
      end

      if (flush) begin
        out_valid <= 1'b0;
      end else if (advance) begin
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (retire && (retired_cnt != CNT_MAX)) begin
        retired_cnt <= retired_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
  import common_pkg::*;

  localparam int unsigned DW = RISC_V_DATA_WIDTH;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_funct7_b5, in_is_rtype, out_ready;
  logic [1:0]    in_alu_op;
  logic [2:0]    in_funct3;
  logic [DW-1:0] in_a, in_b;

  logic          in_ready, out_valid, out_zero, out_illegal, alu_zero;
  logic [DW-1:0] alu_a, alu_b, alu_result, out_result;
  ALU_ctrl_t     alu_ctrl;
  logic [15:0]   retired_cnt;

  logic          in_ready2, out_valid2, out_zero2, out_illegal2, alu_zero2;
  logic [DW-1:0] alu_a2, alu_b2, alu_result2, out_result2;
  ALU_ctrl_t     alu_ctrl2;
  logic [1:0]    retired_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [DW-1:0] res;
    logic          zero;
    logic          ill;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_funct3(in_funct3), .in_funct7_b5(in_funct7_b5),
    .in_is_rtype(in_is_rtype), .in_a(in_a), .in_b(in_b), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_illegal(out_illegal), .retired_cnt(retired_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  alu_issue_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .in_alu_op(in_alu_op), .in_funct3(in_funct3), .in_funct7_b5(in_funct7_b5),
    .in_is_rtype(in_is_rtype), .in_a(in_a), .in_b(in_b), .alu_a(alu_a2), .alu_b(alu_b2),
    .alu_ctrl(alu_ctrl2), .alu_result(alu_result2), .alu_zero(alu_zero2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_result(out_result2),
    .out_zero(out_zero2), .out_illegal(out_illegal2), .retired_cnt(retired_cnt2)
  );

  // Combinational ALU seen by each instance.
  function automatic logic [DW-1:0] alu_model(input ALU_ctrl_t c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (c)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_OR:  return a | b;
      ALU_AND: return a & b;
      default: return '0;
    endcase
  endfunction

  assign alu_result  = alu_model(alu_ctrl, alu_a, alu_b);
  assign alu_zero    = (alu_result == '0);
  assign alu_result2 = alu_model(alu_ctrl2, alu_a2, alu_b2);
  assign alu_zero2   = (alu_result2 == '0);

  // Expected write-back result for an op, straight from the instruction fields.
  function automatic exp_t expect_op(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                                     input logic rt, input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    logic [DW-1:0] r;
    logic ill;
    r = '0;
    ill = 1'b0;
    if (op == 2'b00) r = a + b;
    else if (op == 2'b01) r = a - b;
    else if (op == 2'b11) ill = 1'b1;
    else if (rt && f7) begin
      if (f3 == 3'b000) r = a - b;
      else ill = 1'b1;
    end else begin
      case (f3)
        3'b000:  r = a + b;
        3'b110:  r = a | b;
        3'b111:  r = a & b;
        default: ill = 1'b1;
      endcase
    end
    e.res  = ill ? '0 : r;
    e.zero = ill ? 1'b1 : (r == '0);
    e.ill  = ill;
    return e;
  endfunction

  // Scoreboard: push on accept, pop and compare on each result handshake.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: result %h delivered with nothing outstanding", out_result);
        end else begin
          mon_e = sb.pop_front();
          if ({out_result, out_zero, out_illegal} !== {mon_e.res, mon_e.zero, mon_e.ill}) begin
            n_fail++;
            $display("FAIL sb_result: got res=%h zero=%b ill=%b expected res=%h zero=%b ill=%b",
                     out_result, out_zero, out_illegal, mon_e.res, mon_e.zero, mon_e.ill);
          end
        end
      end
      if (in_valid && in_ready)
        sb.push_back(expect_op(in_alu_op, in_funct3, in_funct7_b5, in_is_rtype, in_a, in_b));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] op, input logic [2:0] f3, input logic f7, input logic rt,
                        input logic [DW-1:0] a, input logic [DW-1:0] b);
    in_valid = 1'b1;
    in_alu_op = op;
    in_funct3 = f3;
    in_funct7_b5 = f7;
    in_is_rtype = rt;
    in_a = a;
    in_b = b;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
    set_op(2'b10, 3'b000, 1'b0, 1'b1, DW'(1), DW'(2));
    tick; tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_checks++; if ({alu_a, alu_b} !== '0) begin n_fail++; $display("FAIL rst_alu_ops: got %h/%h expected 0/0", alu_a, alu_b); end
    n_checks++; if (alu_ctrl !== ALU_ADD) begin n_fail++; $display("FAIL rst_alu_ctrl: got %h expected %h", alu_ctrl, ALU_ADD); end
    n_checks++; if ({out_result, out_zero, out_illegal} !== '0) begin n_fail++; $display("FAIL rst_result: got %h z=%b i=%b expected 0", out_result, out_zero, out_illegal); end
    n_checks++; if (retired_cnt !== 16'd0 || retired_cnt2 !== 2'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d/%0d expected 0/0", retired_cnt, retired_cnt2); end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_add;
    set_op(2'b10, 3'b000, 1'b0, 1'b1, DW'(5), DW'(7));
    tick;
    n_checks++; if (alu_ctrl !== ALU_ADD || alu_a !== DW'(5) || alu_b !== DW'(7)) begin n_fail++; $display("FAIL add_issue: got ctrl=%h a=%0d b=%0d expected ADD 5 7", alu_ctrl, alu_a, alu_b); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_latency: out_valid got %b expected 0 one edge after accept", out_valid); end
    in_valid = 1'b0;
    tick;
    n_checks++; if (out_valid !== 1'b1 || out_result !== DW'(12) || out_zero !== 1'b0 || out_illegal !== 1'b0) begin n_fail++; $display("FAIL add_result: got v=%b r=%0d z=%b i=%b expected 1 12 0 0", out_valid, out_result, out_zero, out_illegal); end
    tick;
  endtask

  task automatic test_sub;
    set_op(2'b01, 3'b000, 1'b0, 1'b0, DW'(9), DW'(9));
    tick;
    in_valid = 1'b0;
    tick;
    n_checks++; if (out_result !== '0 || out_zero !== 1'b1) begin n_fail++; $display("FAIL branch_zero: got r=%h z=%b expected 0 1", out_result, out_zero); end
    tick;
    set_op(2'b10, 3'b000, 1'b1, 1'b1, DW'(3), DW'(5));
    tick;
    n_checks++; if (alu_ctrl !== ALU_SUB) begin n_fail++; $display("FAIL sub_ctrl: got %h expected %h", alu_ctrl, ALU_SUB); end
    in_valid = 1'b0;
    tick;
    n_checks++; if (out_result !== DW'(-2) || out_zero !== 1'b0) begin n_fail++; $display("FAIL sub_result: got %h z=%b expected %h 0", out_result, out_zero, DW'(-2)); end
    tick;
  endtask

  task automatic test_stream;
    logic [15:0] cnt0;
    logic [DW-1:0] exp_r;
    cnt0 = retired_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: set_op(2'b10, 3'b111, 1'b0, 1'b1, DW'(32'hF0), DW'(32'h3C));
        1: set_op(2'b10, 3'b110, 1'b0, 1'b1, DW'(32'hF0), DW'(32'h0F));
        2: set_op(2'b10, 3'b000, 1'b0, 1'b1, DW'(100), DW'(-1));
        3: set_op(2'b10, 3'b000, 1'b1, 1'b0, DW'(10), DW'(20));
        default: in_valid = 1'b0;
      endcase
      tick;
      if (i >= 1 && i <= 4) begin
        case (i)
          1: exp_r = DW'(32'h30);
          2: exp_r = DW'(32'hFF);
          3: exp_r = DW'(99);
          default: exp_r = DW'(30);
        endcase
        n_checks++; if (out_valid !== 1'b1 || out_result !== exp_r) begin n_fail++; $display("FAIL stream_%0d: got v=%b r=%h expected 1 %h", i - 1, out_valid, out_result, exp_r); end
      end
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: out_valid got %b expected 0", out_valid); end
    n_checks++; if (retired_cnt !== cnt0 + 16'd4) begin n_fail++; $display("FAIL stream_cnt: got %0d expected %0d", retired_cnt, cnt0 + 16'd4); end
  endtask

  task automatic test_backpressure;
    logic [15:0] cnt0;
    int k;
    logic acc;
    cnt0 = retired_cnt;
    k = 0;
    for (int c = 0; c < 9; c++) begin
      case (k)
        0: set_op(2'b00, 3'b000, 1'b0, 1'b0, DW'(1), DW'(2));
        1: set_op(2'b01, 3'b000, 1'b0, 1'b0, DW'(10), DW'(4));
        2: set_op(2'b10, 3'b110, 1'b0, 1'b0, DW'(8), DW'(1));
        default: in_valid = 1'b0;
      endcase
      out_ready = (c >= 5);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (c >= 2 && c <= 4) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_c%0d: got %b expected 0", c, in_ready); end
        n_checks++; if (out_valid !== 1'b1 || out_result !== DW'(3)) begin n_fail++; $display("FAIL bp_hold_c%0d: got v=%b r=%0d expected 1 3", c, out_valid, out_result); end
      end
      tick;
      if (acc) k++;
    end
    n_checks++; if (k != 3 || sb.size() != 0) begin n_fail++; $display("FAIL bp_no_loss: accepted %0d outstanding %0d expected 3 0", k, sb.size()); end
    n_checks++; if (out_valid !== 1'b0 || retired_cnt !== cnt0 + 16'd3) begin n_fail++; $display("FAIL bp_cnt: got v=%b cnt=%0d expected 0 %0d", out_valid, retired_cnt, cnt0 + 16'd3); end
  endtask

  task automatic test_illegal;
    logic exp_i;
    logic [DW-1:0] exp_r;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: set_op(2'b11, 3'b000, 1'b0, 1'b1, DW'(4), DW'(4));
        1: set_op(2'b10, 3'b001, 1'b0, 1'b1, DW'(4), DW'(4));
        2: set_op(2'b10, 3'b110, 1'b1, 1'b1, DW'(4), DW'(4));
        3: set_op(2'b10, 3'b111, 1'b1, 1'b0, DW'(6), DW'(3));
        default: in_valid = 1'b0;
      endcase
      tick;
      if (i >= 1 && i <= 4) begin
        exp_i = (i != 4);
        exp_r = exp_i ? '0 : DW'(2);
        n_checks++; if (out_valid !== 1'b1 || out_illegal !== exp_i || out_zero !== exp_i || out_result !== exp_r) begin n_fail++; $display("FAIL illegal_%0d: got v=%b i=%b z=%b r=%h expected 1 %b %b %h", i - 1, out_valid, out_illegal, out_zero, out_result, exp_i, exp_i, exp_r); end
      end
    end
  endtask

  task automatic test_flush;
    logic [15:0] cnt0;
    out_ready = 1'b0;
    set_op(2'b00, 3'b000, 1'b0, 1'b0, DW'(1), DW'(1));
    tick;
    set_op(2'b00, 3'b000, 1'b0, 1'b0, DW'(2), DW'(2));
    tick;
    cnt0 = retired_cnt;
    flush = 1'b1; out_ready = 1'b1;
    set_op(2'b00, 3'b000, 1'b0, 1'b0, DW'(3), DW'(3));
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    tick;
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (retired_cnt !== cnt0 || out_result !== DW'(2)) begin n_fail++; $display("FAIL flush_kept: got cnt=%0d r=%0d expected %0d 2", retired_cnt, out_result, cnt0); end
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: out_valid got %b expected 0", out_valid); end
    set_op(2'b00, 3'b000, 1'b0, 1'b0, DW'(20), DW'(22));
    tick;
    in_valid = 1'b0;
    tick;
    n_checks++; if (out_valid !== 1'b1 || out_result !== DW'(42)) begin n_fail++; $display("FAIL flush_recover: got v=%b r=%0d expected 1 42", out_valid, out_result); end
    tick;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    set_op(2'b00, 3'b000, 1'b0, 1'b0, DW'(7), DW'(8));
    tick;
    set_op(2'b01, 3'b000, 1'b0, 1'b0, DW'(7), DW'(1));
    tick;
    rst = 1'b1; flush = 1'b1;
    tick;
    n_checks++; if (out_valid !== 1'b0 || out_valid2 !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b/%b expected 0/0", out_valid, out_valid2); end
    n_checks++; if ({alu_a, alu_b, out_result, out_zero, out_illegal} !== '0 || alu_ctrl !== ALU_ADD) begin n_fail++; $display("FAIL rstmid_regs: got a=%h b=%h ctrl=%h r=%h z=%b i=%b expected zeros/ADD", alu_a, alu_b, alu_ctrl, out_result, out_zero, out_illegal); end
    n_checks++; if (retired_cnt !== 16'd0 || retired_cnt2 !== 2'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d/%0d expected 0/0", retired_cnt, retired_cnt2); end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_discard: out_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_saturate;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) set_op(2'b00, 3'b000, 1'b0, 1'b0, DW'(i), DW'(1));
      else in_valid = 1'b0;
      tick;
    end
    n_checks++; if (retired_cnt !== 16'd5) begin n_fail++; $display("FAIL sat_wide: got %0d expected 5", retired_cnt); end
    n_checks++; if (retired_cnt2 !== 2'd3) begin n_fail++; $display("FAIL sat_narrow: got %0d expected 3", retired_cnt2); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_alu_op = 2'b00; in_funct3 = 3'b000; in_funct7_b5 = 1'b0; in_is_rtype = 1'b0;
    in_a = '0; in_b = '0;
    #1;
    test_reset;
    test_add;
    test_sub;
    test_stream;
    test_backpressure;
    test_illegal;
    test_flush;
    test_reset_mid;
    test_saturate;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
